// File: rtl/decode_pipe_if.sv
//------------------------------------------------------------------------------
// decode_pipe_if : fetch/control/writeback/execute signal bundle of decode_pipe
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface decode_pipe_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      valid_F_i;
  logic [31:0]               instr_F_i;
  logic [DATA_WIDTH-1:0]     PC_F_i;
  logic [DATA_WIDTH-1:0]     PC_Plus4_F_i;
  logic [31:0]               instrD_o;
  logic [2:0]                ImmSrcD_i;
  logic                      RegWriteW_i;
  logic [REG_ADDR_WIDTH-1:0] RdW_i;
  logic [DATA_WIDTH-1:0]     ResultW_i;
  logic                      MemReadE_i;
  logic [REG_ADDR_WIDTH-1:0] RdE_i;
  logic                      FlushD_i;
  logic                      FlushE_i;
  logic                      StallF_o;
  logic [DATA_WIDTH-1:0]     RD1E_o;
  logic [DATA_WIDTH-1:0]     RD2E_o;
  logic [DATA_WIDTH-1:0]     ImmExtE_o;
  logic [DATA_WIDTH-1:0]     PCE_o;
  logic [DATA_WIDTH-1:0]     PC_Plus4E_o;
  logic [REG_ADDR_WIDTH-1:0] Rs1E_o;
  logic [REG_ADDR_WIDTH-1:0] Rs2E_o;
  logic [REG_ADDR_WIDTH-1:0] RdE_o;
  logic                      validE_o;
  logic [DATA_WIDTH-1:0]     a0_o;

  // Decode stage view
  modport slave (
    input  valid_F_i, instr_F_i, PC_F_i, PC_Plus4_F_i, ImmSrcD_i,
           RegWriteW_i, RdW_i, ResultW_i, MemReadE_i, RdE_i, FlushD_i, FlushE_i,
    output instrD_o, StallF_o, RD1E_o, RD2E_o, ImmExtE_o, PCE_o, PC_Plus4E_o,
           Rs1E_o, Rs2E_o, RdE_o, validE_o, a0_o
  );

  // Surrounding pipeline view
  modport master (
    output valid_F_i, instr_F_i, PC_F_i, PC_Plus4_F_i, ImmSrcD_i,
           RegWriteW_i, RdW_i, ResultW_i, MemReadE_i, RdE_i, FlushD_i, FlushE_i,
    input  instrD_o, StallF_o, RD1E_o, RD2E_o, ImmExtE_o, PCE_o, PC_Plus4E_o,
           Rs1E_o, Rs2E_o, RdE_o, validE_o, a0_o
  );
endinterface

`default_nettype wire

// File: rtl/decode_pipe.sv
//------------------------------------------------------------------------------
// decode_pipe : RISC-V decode stage (IF/ID, regfile, imm extend, hazard, ID/EX)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decode_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_pipe_if.slave  bus
);

  localparam int          c_num_regs  = 2**REG_ADDR_WIDTH;
  localparam logic [31:0] c_nop_instr = 32'h0000_0013;

  typedef struct packed {
    logic                  valid;
    logic [31:0]           instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc4;
  } ifid_t;

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     pc4;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } idex_t;

  ifid_t                     ifid_q, ifid_d;
  idex_t                     idex_q, idex_d;
  logic [DATA_WIDTH-1:0]     rf_q [c_num_regs];
  logic [DATA_WIDTH-1:0]     rf_d [c_num_regs];

  logic [REG_ADDR_WIDTH-1:0] rs1_idx, rs2_idx, rd_idx;
  logic                      wb_en;
  logic [DATA_WIDTH-1:0]     rd1, rd2;
  logic [31:0]               imm32;
  logic [DATA_WIDTH-1:0]     imm_ext;
  logic                      stall;

  // Register fields are resized to the configured index width
  assign rs1_idx = REG_ADDR_WIDTH'(ifid_q.instr[19:15]);
  assign rs2_idx = REG_ADDR_WIDTH'(ifid_q.instr[24:20]);
  assign rd_idx  = REG_ADDR_WIDTH'(ifid_q.instr[11:7]);

  assign wb_en = bus.RegWriteW_i && (bus.RdW_i != '0);

  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[bus.RdW_i] = bus.ResultW_i;
    rf_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_num_regs; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Write-through: a same-cycle writeback is visible to the D-stage read
  always_comb begin
    if (rs1_idx == '0)                       rd1 = '0;
    else if (wb_en && (bus.RdW_i == rs1_idx)) rd1 = bus.ResultW_i;
    else                                      rd1 = rf_q[rs1_idx];
    if (rs2_idx == '0)                       rd2 = '0;
    else if (wb_en && (bus.RdW_i == rs2_idx)) rd2 = bus.ResultW_i;
    else                                      rd2 = rf_q[rs2_idx];
  end

  always_comb begin
    imm32 = '0;
    case (bus.ImmSrcD_i)
      3'b000:  imm32 = {{20{ifid_q.instr[31]}}, ifid_q.instr[31:20]};
      3'b001:  imm32 = {{20{ifid_q.instr[31]}}, ifid_q.instr[31:25], ifid_q.instr[11:7]};
      3'b010:  imm32 = {{20{ifid_q.instr[31]}}, ifid_q.instr[7], ifid_q.instr[30:25],
                        ifid_q.instr[11:8], 1'b0};
      3'b011:  imm32 = {ifid_q.instr[31:12], 12'b0};
      3'b100:  imm32 = {{12{ifid_q.instr[31]}}, ifid_q.instr[19:12], ifid_q.instr[20],
                        ifid_q.instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_ext = DATA_WIDTH'($signed(imm32));

  assign stall = ifid_q.valid && bus.MemReadE_i && (bus.RdE_i != '0) &&
                 ((bus.RdE_i == rs1_idx) || (bus.RdE_i == rs2_idx));

  // Flush beats stall for IF/ID; the stalled instruction is discarded
  always_comb begin
    ifid_d = ifid_q;
    if (bus.FlushD_i) begin
      ifid_d       = '0;
      ifid_d.instr = c_nop_instr;
    end else if (!stall) begin
      ifid_d.valid = bus.valid_F_i;
      ifid_d.instr = bus.instr_F_i;
      ifid_d.pc    = bus.PC_F_i;
      ifid_d.pc4   = bus.PC_Plus4_F_i;
    end
  end

  always_comb begin
    idex_d = '0;
    if (!(bus.FlushE_i || stall)) begin
      idex_d.valid = ifid_q.valid;
      idex_d.rd1   = rd1;
      idex_d.rd2   = rd2;
      idex_d.imm   = imm_ext;
      idex_d.pc    = ifid_q.pc;
      idex_d.pc4   = ifid_q.pc4;
      idex_d.rs1   = rs1_idx;
      idex_d.rs2   = rs2_idx;
      idex_d.rd    = rd_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q <= '0;
      idex_q <= '0;
    end else begin
      ifid_q <= ifid_d;
      idex_q <= idex_d;
    end
  end

  assign bus.instrD_o    = ifid_q.instr;
  assign bus.StallF_o    = stall;
  assign bus.RD1E_o      = idex_q.rd1;
  assign bus.RD2E_o      = idex_q.rd2;
  assign bus.ImmExtE_o   = idex_q.imm;
  assign bus.PCE_o       = idex_q.pc;
  assign bus.PC_Plus4E_o = idex_q.pc4;
  assign bus.Rs1E_o      = idex_q.rs1;
  assign bus.Rs2E_o      = idex_q.rs2;
  assign bus.RdE_o       = idex_q.rd;
  assign bus.validE_o    = idex_q.valid;

  generate
    if (c_num_regs > 10) begin : g_a0
      assign bus.a0_o = rf_q[10];
    end else begin : g_no_a0
      assign bus.a0_o = '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_decode_pipe.sv
//------------------------------------------------------------------------------
// tb_decode_pipe : directed self-checking bench for decode_pipe
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_decode_pipe;

  localparam int DW  = 32;
  localparam int RAW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  decode_pipe_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) bus ();

  decode_pipe #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] exp;
  } imm_vec_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_f(input logic [31:0] instr, input logic [31:0] pc);
    bus.valid_F_i    = 1'b1;
    bus.instr_F_i    = instr;
    bus.PC_F_i       = pc;
    bus.PC_Plus4_F_i = pc + 32'd4;
  endtask

  task automatic idle_f();
    bus.valid_F_i    = 1'b0;
    bus.instr_F_i    = 32'h0000_0013;
    bus.PC_F_i       = '0;
    bus.PC_Plus4_F_i = '0;
  endtask

  // Present, decode with the given immediate format, land in E
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] src);
    load_f(instr, pc);
    step();
    bus.ImmSrcD_i = src;
    idle_f();
    step();
  endtask

  task automatic check_addi_after_reset();
    issue(32'h0050_0093, 32'h100, 3'b000);
    check("addi_rd",    bus.RdE_o,       5'd1);
    check("addi_imm",   bus.ImmExtE_o,   32'd5);
    check("addi_pc",    bus.PCE_o,       32'h100);
    check("addi_pc4",   bus.PC_Plus4E_o, 32'h104);
    check("addi_valid", bus.validE_o,    1'b1);
    check("addi_rd1",   bus.RD1E_o,      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  imm_vec_t imm_vecs [6];

  initial begin
    imm_vecs[0] = '{32'hFFF0_0093, 3'b000, 32'hFFFF_FFFF};
    imm_vecs[1] = '{32'h0011_2623, 3'b001, 32'h0000_000C};
    imm_vecs[2] = '{32'hFE00_0EE3, 3'b010, 32'hFFFF_FFFC};
    imm_vecs[3] = '{32'hABCD_E2B7, 3'b011, 32'hABCD_E000};
    imm_vecs[4] = '{32'h0080_006F, 3'b100, 32'h0000_0008};
    imm_vecs[5] = '{32'hFFF0_0093, 3'b101, 32'h0000_0000};

    idle_f();
    bus.ImmSrcD_i   = 3'b000;
    bus.RegWriteW_i = 1'b0;
    bus.RdW_i       = '0;
    bus.ResultW_i   = '0;
    bus.MemReadE_i  = 1'b0;
    bus.RdE_i       = '0;
    bus.FlushD_i    = 1'b0;
    bus.FlushE_i    = 1'b0;

    #2;
    check("rst_validE", bus.validE_o,  1'b0);
    check("rst_instrD", bus.instrD_o,  32'h0);
    check("rst_stall",  bus.StallF_o,  1'b0);
    check("rst_a0",     bus.a0_o,      32'h0);
    check("rst_pcE",    bus.PCE_o,     32'h0);
    check("rst_immE",   bus.ImmExtE_o, 32'h0);
    #1 rst_n = 1'b1;

    check_addi_after_reset();

    foreach (imm_vecs[i]) begin
      issue(imm_vecs[i].instr, 32'h200 + 32'(i * 4), imm_vecs[i].src);
      check($sformatf("imm_%0d", i), bus.ImmExtE_o, imm_vecs[i].exp);
    end
    bus.ImmSrcD_i = 3'b000;

    // addi x4, x3, 0 with x3 being written back in the same cycle
    load_f(32'h0001_8213, 32'h120);
    step();
    bus.RegWriteW_i = 1'b1;
    bus.RdW_i       = 5'd3;
    bus.ResultW_i   = 32'hDEAD;
    idle_f();
    step();
    bus.RegWriteW_i = 1'b0;
    check("wt_rd1", bus.RD1E_o, 32'hDEAD);
    check("wt_rs1", bus.Rs1E_o, 5'd3);
    check("wt_rd",  bus.RdE_o,  5'd4);
    issue(32'h0001_8213, 32'h124, 3'b000);
    check("rf_x3",  bus.RD1E_o, 32'hDEAD);

    // add x6, x0, x0 while a write to x0 is attempted
    load_f(32'h0000_0333, 32'h130);
    step();
    bus.RegWriteW_i = 1'b1;
    bus.RdW_i       = 5'd0;
    bus.ResultW_i   = 32'h1234;
    idle_f();
    step();
    bus.RegWriteW_i = 1'b0;
    check("x0_rd1", bus.RD1E_o, 32'h0);
    check("x0_rd2", bus.RD2E_o, 32'h0);
    check("x0_rd",  bus.RdE_o,  5'd6);

    // Load-use: add x7, x6, x5 behind a load to x5
    load_f(32'h0053_03B3, 32'h200);
    step();
    bus.MemReadE_i = 1'b1;
    bus.RdE_i      = 5'd5;
    load_f(32'h0010_0413, 32'h204);
    #1;
    check("lu_stall", bus.StallF_o, 1'b1);
    step();
    bus.MemReadE_i = 1'b0;
    bus.RdE_i      = '0;
    #1;
    check("lu_stall_drop", bus.StallF_o, 1'b0);
    check("lu_hold",       bus.instrD_o, 32'h0053_03B3);
    check("lu_bub_valid",  bus.validE_o, 1'b0);
    check("lu_bub_pc",     bus.PCE_o,    32'h0);
    check("lu_bub_rs2",    bus.Rs2E_o,   5'd0);
    check("lu_bub_rd",     bus.RdE_o,    5'd0);
    step();
    check("lu_iss_valid", bus.validE_o,    1'b1);
    check("lu_iss_pc",    bus.PCE_o,       32'h200);
    check("lu_iss_pc4",   bus.PC_Plus4E_o, 32'h204);
    check("lu_iss_rs1",   bus.Rs1E_o,      5'd6);
    check("lu_iss_rs2",   bus.Rs2E_o,      5'd5);
    check("lu_iss_rd",    bus.RdE_o,       5'd7);
    check("lu_next_D",    bus.instrD_o,    32'h0010_0413);
    idle_f();
    step();
    check("lu_next_pc",  bus.PCE_o,     32'h204);
    check("lu_next_imm", bus.ImmExtE_o, 32'd1);

    // Both flushes together
    load_f(32'h0050_0093, 32'h300);
    step();
    bus.FlushD_i = 1'b1;
    bus.FlushE_i = 1'b1;
    load_f(32'h0010_0413, 32'h304);
    step();
    bus.FlushD_i = 1'b0;
    bus.FlushE_i = 1'b0;
    idle_f();
    #1;
    check("fl_valid",  bus.validE_o,  1'b0);
    check("fl_pc",     bus.PCE_o,     32'h0);
    check("fl_imm",    bus.ImmExtE_o, 32'h0);
    check("fl_rd",     bus.RdE_o,     5'd0);
    check("fl_instrD", bus.instrD_o,  32'h0000_0013);
    step();
    check("fl_next_valid", bus.validE_o, 1'b0);

    // Flush arriving while a load-use stall is pending
    load_f(32'h0053_03B3, 32'h400);
    step();
    bus.MemReadE_i = 1'b1;
    bus.RdE_i      = 5'd5;
    bus.FlushD_i   = 1'b1;
    load_f(32'h0010_0413, 32'h404);
    #1;
    check("fs_stall", bus.StallF_o, 1'b1);
    step();
    bus.FlushD_i   = 1'b0;
    bus.MemReadE_i = 1'b0;
    bus.RdE_i      = '0;
    #1;
    check("fs_instrD", bus.instrD_o, 32'h0000_0013);
    check("fs_bubble", bus.validE_o, 1'b0);
    step();
    check("fs_discard", bus.validE_o, 1'b0);
    check("fs_next_D",  bus.instrD_o, 32'h0010_0413);
    idle_f();
    step();
    check("fs_next_valid", bus.validE_o, 1'b1);
    check("fs_next_pc",    bus.PCE_o,    32'h404);

    // a0 tracks x10 after the write edge
    bus.RegWriteW_i = 1'b1;
    bus.RdW_i       = 5'd10;
    bus.ResultW_i   = 32'd42;
    #1;
    check("a0_before", bus.a0_o, 32'd0);
    step();
    bus.RegWriteW_i = 1'b0;
    #1;
    check("a0_after", bus.a0_o, 32'd42);

    // Asynchronous reset in the middle of a live pipeline
    issue(32'h0050_0093, 32'h500, 3'b000);
    check("pre_rst_valid", bus.validE_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_valid",  bus.validE_o, 1'b0);
    check("arst_pc",     bus.PCE_o,    32'h0);
    check("arst_rd",     bus.RdE_o,    5'd0);
    check("arst_instrD", bus.instrD_o, 32'h0);
    check("arst_a0",     bus.a0_o,     32'h0);
    #1 rst_n = 1'b1;
    #1;
    check_addi_after_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
